ip_ingress_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single byte-wide IP parser among `NUM_PORTS` Ethernet-parser output streams. It grants one AXI-Stream source at a time and holds the grant for a whole frame, from the first beat through the `tlast` handshake. While granted, the source's data, last and user fields pass straight through to the IP parser's slave port. An optional watchdog aborts frames whose source starves mid-packet, so one stalled port cannot lock the shared parser.

---
 rtl/ip_ingress_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ip_ingress_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ip_ingress_arbiter.sv
// ip_ingress_arbiter
//   Packet-level round-robin arbiter feeding one byte-wide IP parser from
//   NUM_PORTS AXI-Stream sources. A grant is held from the first beat
//   through the tlast handshake. While a port is granted, its data, last and
//   user fields pass combinationally to the master side.
//
//   Optional build macro ARB_TIMEOUT_EN adds a starvation watchdog. When a
//   granted source stalls mid-frame for TIMEOUT_CYCLES, the block emits one
//   synthetic abort beat. It then silently drains the rest of that frame.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   s_axis_*        per-port slave streams, port i at [i*W +: W]
//   m_axis_*        master stream to the IP parser; tid = granted port,
//                   tabort marks the synthetic abort beat
//   grant           one-hot grant, zero while idle
module ip_ingress_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_PORTS      = 4,
  parameter int USER_WIDTH     = 18,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  output logic [IDX_W-1:0]                m_axis_tid,
  output logic                            m_axis_tabort,
  input  logic                            m_axis_tready,
  output logic [NUM_PORTS-1:0]            grant
);

  typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] tdata_a;
  logic [NUM_PORTS-1:0][USER_WIDTH-1:0] tuser_a;
  assign tdata_a = s_axis_tdata;
  assign tuser_a = s_axis_tuser;

  logic sel_valid, sel_last, sel_beat;
  assign sel_valid = s_axis_tvalid[gnt_idx_q];
  assign sel_last  = s_axis_tlast[gnt_idx_q];
  assign sel_beat  = sel_valid & m_axis_tready;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_PORTS - 1)) ? '0 : i + 1'b1;
  endfunction

  // Rotating priority scan. Walk the offsets downward so that the smallest
  // offset from rr_ptr is the last write and therefore wins.
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (s_axis_tvalid[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
`else
  // The watchdog limit has no effect in this build.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES < 2);
`endif

  // Output steering. All outputs are forced to zero in IDLE, which reset
  // also selects.
  always_comb begin
    s_axis_tready = '0;
    grant         = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    m_axis_tid    = '0;
    m_axis_tabort = 1'b0;
    unique case (state_q)
      XFER: begin
        grant[gnt_idx_q]         = 1'b1;
        s_axis_tready[gnt_idx_q] = m_axis_tready;
        m_axis_tdata             = tdata_a[gnt_idx_q];
        m_axis_tvalid            = sel_valid;
        m_axis_tlast             = sel_last;
        m_axis_tuser             = tuser_a[gnt_idx_q];
        m_axis_tid               = gnt_idx_q;
      end
`ifdef ARB_TIMEOUT_EN
      ABORT: begin
        grant[gnt_idx_q] = 1'b1;
        m_axis_tvalid    = 1'b1;
        m_axis_tlast     = 1'b1;
        m_axis_tabort    = 1'b1;
        m_axis_tid       = gnt_idx_q;
      end
      DRAIN: begin
        // Sink the rest of the aborted frame without forwarding it.
        grant[gnt_idx_q]         = 1'b1;
        s_axis_tready[gnt_idx_q] = 1'b1;
        m_axis_tid               = gnt_idx_q;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    timer_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_idx_d = pick_idx;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (sel_beat && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(gnt_idx_q);
        end
`ifdef ARB_TIMEOUT_EN
        // The timer holds while a valid beat waits on the master side.
        // Only a starved source advances it.
        else if (sel_beat) timer_d = '0;
        else if (!sel_valid) begin
          if (timer_q == TW'(TIMEOUT_CYCLES - 1)) state_d = ABORT;
          else                                    timer_d = timer_q + 1'b1;
        end else timer_d = timer_q;
`endif
      end
`ifdef ARB_TIMEOUT_EN
      ABORT: if (m_axis_tready) state_d = DRAIN;
      DRAIN: begin
        if (sel_valid && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(gnt_idx_q);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
`ifdef ARB_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
`ifdef ARB_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_ip_ingress_arbiter.sv
// Directed bench for ip_ingress_arbiter (4 ports, byte data, 18-bit user).
// Inputs change 1 ns after each rising edge. Outputs are checked 1 ns later.
// A handshake monitor records every forwarded byte for an end-of-run
// ordering check.
module tb_ip_ingress_arbiter;
  localparam int NP = 4;

  logic                 clk, rst_n;
  logic [NP-1:0][7:0]   tdata_a;
  logic [NP-1:0][17:0]  tuser_a;
  logic [NP-1:0]        tvalid, tlast, s_ready, grant;
  logic [7:0]           m_tdata;
  logic                 m_tvalid, m_tlast, m_tabort, m_ready;
  logic [17:0]          m_tuser;
  logic [1:0]           m_tid;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  ip_ingress_arbiter #(.DATA_WIDTH(8), .NUM_PORTS(NP), .USER_WIDTH(18),
                       .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tuser(tuser_a), .s_axis_tready(s_ready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tid(m_tid), .m_axis_tabort(m_tabort),
    .m_axis_tready(m_ready), .grant(grant));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && m_tvalid && m_ready && !m_tabort) rx.push_back(m_tdata);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drv(input int p, input logic v, input logic [7:0] d,
                     input logic l, input logic [17:0] u);
    tvalid[p] = v; tdata_a[p] = d; tlast[p] = l; tuser_a[p] = u;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"},  32'(grant),    32'h0);
    chk({tag, "_mvalid"}, 32'(m_tvalid), 32'h0);
    chk({tag, "_sready"}, 32'(s_ready),  32'h0);
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b0;
    tvalid = '0; tlast = '0; tdata_a = '0; tuser_a = '0;
    #2;
    chk_idle("rst");
    chk("rst_tid", 32'(m_tid), 0);
    chk("rst_tabort", 32'(m_tabort), 0);
    cyc(); cyc(); rst_n = 1'b1;

    // ---- port 2, 3-byte frame ----
    cyc(); m_ready = 1'b1; drv(2, 1, 8'h45, 0, 18'h2A5A); #1;
    chk_idle("t1_req");
    cyc(); #1;
    chk("t1_grant", 32'(grant), 32'b0100);
    chk("t1_tid", 32'(m_tid), 2);
    chk("t1_b0", 32'(m_tdata), 32'h45);
    chk("t1_user", 32'(m_tuser), 32'h2A5A);
    chk("t1_sready", 32'(s_ready), 32'b0100);
    exp_q.push_back(8'h45);
    cyc(); drv(2, 1, 8'h00, 0, 18'h2A5A); #1;
    chk("t1_b1", 32'(m_tdata), 32'h00); exp_q.push_back(8'h00);
    cyc(); drv(2, 1, 8'h11, 1, 18'h2A5A); #1;
    chk("t1_b2", 32'(m_tdata), 32'h11);
    chk("t1_last", 32'(m_tlast), 1); exp_q.push_back(8'h11);
    cyc(); drv(2, 0, 8'h00, 0, 18'h0); #1;
    chk_idle("t1_end");

    // ---- ports 0 and 3 contend after reset, port 0 re-requests ----
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    cyc(); drv(0, 1, 8'hA0, 0, 18'h1); drv(3, 1, 8'hB0, 0, 18'h3); #1;
    chk_idle("t2_req");
    cyc(); #1;
    chk("t2_g0", 32'(grant), 32'b0001);
    chk("t2_a0", 32'(m_tdata), 32'hA0); exp_q.push_back(8'hA0);
    cyc(); drv(0, 1, 8'hA1, 1, 18'h1); #1;
    chk("t2_a1", 32'(m_tdata), 32'hA1); exp_q.push_back(8'hA1);
    cyc(); drv(0, 1, 8'hC0, 0, 18'h1); #1;
    chk_idle("t2_gap1");
    cyc(); #1;
    chk("t2_g3", 32'(grant), 32'b1000);
    chk("t2_tid3", 32'(m_tid), 3);
    chk("t2_b0", 32'(m_tdata), 32'hB0); exp_q.push_back(8'hB0);
    cyc(); drv(3, 1, 8'hB1, 1, 18'h3); #1;
    chk("t2_b1", 32'(m_tdata), 32'hB1); exp_q.push_back(8'hB1);
    cyc(); drv(3, 0, 8'h00, 0, 18'h0); #1;
    chk_idle("t2_gap2");
    cyc(); #1;
    chk("t2_g0b", 32'(grant), 32'b0001);
    chk("t2_c0", 32'(m_tdata), 32'hC0); exp_q.push_back(8'hC0);
    cyc(); drv(0, 1, 8'hC1, 1, 18'h1); #1;
    exp_q.push_back(8'hC1);

    // ---- port 1 under 5 cycles of backpressure ----
    cyc(); drv(0, 0, 8'h00, 0, 18'h0); drv(1, 1, 8'hD0, 0, 18'h2); #1;
    chk_idle("t3_gap");
    cyc(); #1;
    chk("t3_g1", 32'(grant), 32'b0010);
    chk("t3_d0", 32'(m_tdata), 32'hD0);
    chk("t3_rdy", 32'(s_ready), 32'b0010); exp_q.push_back(8'hD0);
    cyc(); drv(1, 1, 8'hD1, 0, 18'h2); m_ready = 1'b0; #1;
    chk("t3_hold_rdy0", 32'(s_ready), 0);
    chk("t3_hold_d0", 32'(m_tdata), 32'hD1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk($sformatf("t3_hold_rdy%0d", i + 1), 32'(s_ready), 0);
      chk($sformatf("t3_hold_v%0d", i + 1), 32'(m_tvalid), 1);
    end
    cyc(); m_ready = 1'b1; #1;
    chk("t3_release", 32'(s_ready), 32'b0010);
    chk("t3_d1", 32'(m_tdata), 32'hD1); exp_q.push_back(8'hD1);
    cyc(); drv(1, 1, 8'hD2, 1, 18'h2); #1;
    chk("t3_d2", 32'(m_tdata), 32'hD2); exp_q.push_back(8'hD2);
    cyc(); drv(1, 0, 8'h00, 0, 18'h0); #1;
    chk_idle("t3_end");

    // ---- reset in the middle of a port-3 frame ----
    cyc(); drv(3, 1, 8'hE0, 0, 18'h3); #1;
    cyc(); #1;
    chk("t5_g3", 32'(grant), 32'b1000); exp_q.push_back(8'hE0);
    cyc(); drv(3, 1, 8'hE1, 1, 18'h3); #1;
    rst_n = 1'b0; #1;
    chk_idle("t5_rst");
    chk("t5_rst_tdata", 32'(m_tdata), 0);
    chk("t5_rst_tid", 32'(m_tid), 0);
    chk("t5_rr", 32'(dut.rr_ptr_q), 0);
    cyc(); rst_n = 1'b1; #1;
    chk_idle("t5_post");
    cyc(); #1;
    chk("t5_regrant", 32'(grant), 32'b1000);
    chk("t5_e1", 32'(m_tdata), 32'hE1); exp_q.push_back(8'hE1);
    cyc(); drv(3, 0, 8'h00, 0, 18'h0); #1;
    chk_idle("t5_end");

`ifdef ARB_TIMEOUT_EN
    // ---- port 0 starves mid-frame, watchdog aborts and drains ----
    cyc(); drv(0, 1, 8'hF0, 0, 18'h1); #1;
    cyc(); #1;
    chk("to_g0", 32'(grant), 32'b0001); exp_q.push_back(8'hF0);
    cyc(); drv(0, 1, 8'hF1, 0, 18'h1); #1; exp_q.push_back(8'hF1);
    cyc(); drv(0, 0, 8'h00, 0, 18'h1); drv(1, 1, 8'h90, 1, 18'h2); #1;
    chk("to_idle0", 32'(m_tvalid), 0);
    for (int i = 0; i < 7; i++) begin
      cyc(); #1;
      chk($sformatf("to_wait%0d", i + 1), 32'(m_tabort), 0);
    end
    cyc(); #1;
    chk("to_abort_v", 32'(m_tvalid), 1);
    chk("to_abort_l", 32'(m_tlast), 1);
    chk("to_abort_a", 32'(m_tabort), 1);
    chk("to_abort_d", 32'(m_tdata), 0);
    chk("to_abort_r", 32'(s_ready), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(0, 1, 8'h60 + 8'(i), (i == 3), 18'h1); #1;
      chk($sformatf("to_drain_r%0d", i), 32'(s_ready), 32'b0001);
      chk($sformatf("to_drain_v%0d", i), 32'(m_tvalid), 0);
    end
    cyc(); drv(0, 0, 8'h00, 0, 18'h0); #1;
    chk("to_gap", 32'(grant), 0);
    cyc(); #1;
    chk("to_g1", 32'(grant), 32'b0010);
    chk("to_h0", 32'(m_tdata), 32'h90); exp_q.push_back(8'h90);
    cyc(); drv(1, 0, 8'h00, 0, 18'h0); #1;
`endif

    // ---- forwarded byte stream: order, no loss, no duplicates ----
    chk("sb_count", 32'(rx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      chk($sformatf("sb_byte%0d", i), 32'(rx[i]), 32'(exp_q[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
